// File: rtl/spi_read_ip_pkg.sv
// Shared definitions for the SPI read engine: FSM state encoding (also used
// by the write FSM), shift-register opcodes, idle clock level and defaults.
package spi_read_ip_pkg;

  localparam int NBITS_DEF = 12;
  localparam int KW_DEF    = 8;

  // DCLK level whenever no bit cell is in progress
  localparam logic DCLK_IDLE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_CLEAR = 2'd1,
    SR_SHIFT = 2'd2
  } sipo_op_e;

  // chip-select is asserted for the whole framed part of a transaction
  function automatic logic frame_active(spi_state_e s);
    return (s == START) || (s == LOW) || (s == HIGH);
  endfunction

endpackage

// File: rtl/spi_read_ip_if.sv
// Controller/ADC-side bundle of the SPI read engine.
// master: top-level controller plus serial slave; slave: the read engine.
interface spi_read_ip_if #(
  parameter int NBITS = spi_read_ip_pkg::NBITS_DEF,
  parameter int KW    = spi_read_ip_pkg::KW_DEF
);
  logic             strr_i;
  logic [KW-1:0]    kmax_i;
  logic             miso_i;
  logic [NBITS-1:0] data_o;
  logic             dclk_o;
  logic             cs_o;
  logic             busy_o;
  logic             eor_o;

  modport master (
    output strr_i, kmax_i, miso_i,
    input  data_o, dclk_o, cs_o, busy_o, eor_o
  );

  modport slave (
    input  strr_i, kmax_i, miso_i,
    output data_o, dclk_o, cs_o, busy_o, eor_o
  );
endinterface

// File: rtl/spi_read_ip_sipo_reg.sv
// Serial-in / parallel-out shift register, MSB first (left shift).
// Counterpart of piso_reg on the write path.
module sipo_reg
  import spi_read_ip_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  sipo_op_e         op,
  input  logic             sin,
  output logic [NBITS-1:0] pout
);

  logic [NBITS-1:0] sr_q;

  // hold / clear / shift-left with the new bit entering at the LSB
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sr_q <= '0;
    end else begin
      unique case (op)
        SR_CLEAR: sr_q <= '0;
        SR_SHIFT: sr_q <= {sr_q[NBITS-2:0], sin};
        default:  sr_q <= sr_q;
      endcase
    end
  end

  assign pout = sr_q;

endmodule

// File: rtl/spi_read_ip.sv
// SPI master receive engine for the ADC serial link.
// A start request frames a transaction with cs_o, generates DCLK with a
// half-period of kmax_i+1 clocks and shifts NBITS bits MSB first.
// Build option SPI_READ_NULL_BIT_EN: issue one extra leading DCLK cycle
// whose bit (the ADC null bit) falls off the top of the shift register.
//
// state | meaning
// IDLE  | cs high, waiting for strr_i
// START | cs setup, one half-period with DCLK low
// LOW   | DCLK low half-period; decides next bit or finish
// HIGH  | DCLK high half-period; bit sampled on entry
// DONE  | one cycle: cs high, eor pulse, word presented
module spi_read_ip
  import spi_read_ip_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int KW    = KW_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  spi_read_ip_if.slave bus
);

`ifdef SPI_READ_NULL_BIT_EN
  localparam int NRISE = NBITS + 1;
`else
  localparam int NRISE = NBITS;
`endif
  localparam int BCW = $clog2(NRISE + 1);
  localparam logic [BCW-1:0] BITS_LAST = BCW'(NRISE);

  spi_state_e       state_q, state_d;
  logic [KW-1:0]    kmax_q;
  logic [KW-1:0]    div_q;
  logic [BCW-1:0]   bits_q;
  logic [NBITS-1:0] sr;
  logic [NBITS-1:0] data_q;
  sipo_op_e         sr_op;
  logic             div_zero;
  logic             state_chg;
  logic             cs_n, dclk, busy, eor;

  assign div_zero  = (div_q == '0);
  assign state_chg = (state_d != state_q);

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state, shift-register control and Moore outputs
  always_comb begin
    state_d = state_q;
    sr_op   = SR_HOLD;
    cs_n    = ~frame_active(state_q);
    dclk    = DCLK_IDLE;
    busy    = frame_active(state_q);
    eor     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.strr_i) begin
          state_d = START;
          sr_op   = SR_CLEAR;
        end
      end
      START: begin
        if (div_zero) state_d = LOW;
      end
      LOW: begin
        if (div_zero) begin
          if (bits_q < BITS_LAST) begin
            state_d = HIGH;
            sr_op   = SR_SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      HIGH: begin
        dclk = ~DCLK_IDLE;
        if (div_zero) state_d = LOW;
      end
      DONE: begin
        eor     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // divider: reload on every state change, else count down and park at 0;
  // kmax is captured only when a transaction is accepted
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      kmax_q <= '0;
      div_q  <= '0;
    end else if (state_chg) begin
      if (state_q == IDLE) begin
        kmax_q <= bus.kmax_i;
        div_q  <= bus.kmax_i;
      end else begin
        div_q  <= kmax_q;
      end
    end else if (!div_zero) begin
      div_q <= div_q - 1'b1;
    end
  end

  // bit counter: cleared on acceptance, saturates at the rising-edge count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bits_q <= '0;
    end else if (sr_op == SR_CLEAR) begin
      bits_q <= '0;
    end else if ((sr_op == SR_SHIFT) && (bits_q != BITS_LAST)) begin
      bits_q <= bits_q + 1'b1;
    end
  end

  sipo_reg #(.NBITS(NBITS)) u_sipo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .op    (sr_op),
    .sin   (bus.miso_i),
    .pout  (sr)
  );

  // output word changes only when a complete frame reaches DONE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                 data_q <= '0;
    else if (state_chg && (state_d == DONE))    data_q <= sr;
  end

  assign bus.data_o = data_q;
  assign bus.dclk_o = dclk;
  assign bus.cs_o   = cs_n;
  assign bus.busy_o = busy;
  assign bus.eor_o  = eor;

endmodule

// File: tb/tb_spi_read_ip.sv
// Directed bench for spi_read_ip: drives the controller side, models the
// ADC shifting out MSB first on falling DCLK, and measures the frame.
module tb_spi_read_ip;
  import spi_read_ip_pkg::*;

  localparam int NBITS = 12;
  localparam int KW    = 8;
`ifdef SPI_READ_NULL_BIT_EN
  localparam int NB = 1;
`else
  localparam int NB = 0;
`endif
  localparam int TOTAL = NBITS + NB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  spi_read_ip_if #(.NBITS(NBITS), .KW(KW)) sif ();

  spi_read_ip #(.NBITS(NBITS), .KW(KW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ADC model: first bit on cs fall, next bit on every falling DCLK
  logic [TOTAL-1:0] tx_word = '0;
  int tx_idx = TOTAL;
  always @(sif.cs_o or negedge sif.dclk_o) begin
    if (sif.cs_o) tx_idx = TOTAL;
    else if (tx_idx > 0) begin
      tx_idx--;
      sif.miso_i = tx_word[tx_idx];
    end
  end

  // frame monitor sampled on the falling clock edge
  int cs_low_tot = 0, rise_tot = 0, hi_bad_tot = 0;
  int eor_tot = 0, eor_long_tot = 0, busy_bad_tot = 0;
  int exp_h = 4;
  int hi_run = 0;
  logic dclk_prev = 1'b0, eor_prev = 1'b0;
  always @(negedge clk) begin
    if (!sif.cs_o) cs_low_tot++;
    if (sif.dclk_o && !dclk_prev) rise_tot++;
    if (sif.dclk_o) hi_run++;
    else begin
      if (hi_run != 0 && hi_run != exp_h) hi_bad_tot++;
      hi_run = 0;
    end
    if (sif.eor_o) eor_tot++;
    if (sif.eor_o && eor_prev) eor_long_tot++;
    if (sif.busy_o !== !sif.cs_o) busy_bad_tot++;
    dclk_prev = sif.dclk_o;
    eor_prev  = sif.eor_o;
  end

  int c0, r0, h0, e0, l0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    c0 = cs_low_tot; r0 = rise_tot; h0 = hi_bad_tot; e0 = eor_tot; l0 = eor_long_tot;
  endtask

  task automatic start_read(input int k, input logic [NBITS-1:0] w);
    tx_word    = TOTAL'({1'b1, w});
    exp_h      = k + 1;
    sif.kmax_i = KW'(k);
    snap();
    sif.strr_i = 1'b1;
    step();
    sif.strr_i = 1'b0;
  endtask

  task automatic wait_eor(input string tag);
    for (int i = 0; i < 5000; i++) begin
      if (sif.eor_o) break;
      step();
    end
    check({tag, " eor_timeout"}, sif.eor_o, 1'b1);
  endtask

  task automatic finish_read(input int k, input logic [NBITS-1:0] w, input string tag);
    wait_eor(tag);
    step();
    check({tag, " data"},     sif.data_o, w);
    check({tag, " cs_low"},   cs_low_tot - c0, (2 * TOTAL + 2) * (k + 1));
    check({tag, " rises"},    rise_tot - r0, TOTAL);
    check({tag, " hi_width"}, hi_bad_tot - h0, 0);
    check({tag, " eor_cnt"},  eor_tot - e0, 1);
    check({tag, " eor_len"},  eor_long_tot - l0, 0);
  endtask

  task automatic do_read(input int k, input logic [NBITS-1:0] w, input string tag);
    start_read(k, w);
    finish_read(k, w, tag);
  endtask

  int n;

  initial begin
    sif.strr_i = 1'b0;
    sif.kmax_i = 8'd3;
    #1 rst_n = 1'b0;
    #3;
    check("rst cs",   sif.cs_o,   1'b1);
    check("rst dclk", sif.dclk_o, 1'b0);
    check("rst busy", sif.busy_o, 1'b0);
    check("rst eor",  sif.eor_o,  1'b0);
    check("rst data", sif.data_o, 12'h000);
    step();
    rst_n = 1'b1;
    step();

    do_read(3, 12'hA5C, "basic");
    do_read(0, 12'hFFF, "min_ones");
    do_read(0, 12'h000, "min_zeros");

    // start pulse in the middle of a frame is ignored
    start_read(3, 12'h5A3);
    repeat (30) step();
    check("mid busy", sif.busy_o, 1'b1);
    sif.strr_i = 1'b1;
    step();
    sif.strr_i = 1'b0;
    finish_read(3, 12'h5A3, "mid");
    repeat (10) step();
    check("mid no_restart cs", sif.cs_o, 1'b1);
    check("mid no_restart eor", eor_tot - e0, 1);

    // strr held high: next frame begins two cycles after eor
    tx_word = TOTAL'({1'b1, 12'hC36});
    exp_h = 4;
    sif.kmax_i = 8'd3;
    snap();
    sif.strr_i = 1'b1;
    wait_eor("b2b first");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (!sif.cs_o) break;
    end
    check("b2b cs_gap", n, 2);
    sif.strr_i = 1'b0;
    wait_eor("b2b second");
    step();
    check("b2b data",   sif.data_o, 12'hC36);
    check("b2b eor_cnt", eor_tot - e0, 2);
    check("b2b rises",  rise_tot - r0, 2 * TOTAL);
    check("b2b cs_low", cs_low_tot - c0, 2 * (2 * TOTAL + 2) * 4);

    // asynchronous reset after five bits
    start_read(3, 12'h123);
    for (int i = 0; i < 500; i++) begin
      if ((rise_tot - r0) >= 5 && !sif.dclk_o) break;
      step();
    end
    check("rst_mid reached", rise_tot - r0, 5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid cs",   sif.cs_o,   1'b1);
    check("rst_mid dclk", sif.dclk_o, 1'b0);
    check("rst_mid busy", sif.busy_o, 1'b0);
    check("rst_mid data", sif.data_o, 12'h000);
    step();
    rst_n = 1'b1;
    step();
    do_read(3, 12'h9E7, "after_rst");

    // kmax change after acceptance only affects the next frame
    start_read(3, 12'h6B1);
    repeat (3) step();
    sif.kmax_i = 8'd7;
    finish_read(3, 12'h6B1, "kchg");
    do_read(7, 12'h1F0, "k7");

    do_read(3, 12'h3C3, "nullbit");

    check("busy_vs_cs", busy_bad_tot, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
